fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with a QDEPTH-entry instruction queue
// Optional FETCH_BYPASS_EN: a response that meets an empty queue goes straight to decode.
module fetch_unit #(
  parameter int QDEPTH = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pc_actual,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int PW = (QDEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic [31:0]   instr_mem_q [QDEPTH];
  logic [31:0]   pc_mem_q    [QDEPTH];

  logic head_valid, resp, accept, bypass, pop, push;

  always_comb begin
    head_valid = (count_q != '0);
    resp       = (state_q == WAIT) && imem_rvalid && !redirect;
    // Reset is folded in so the request drops without waiting for a clock edge.
    imem_req   = !reset && (state_q == IDLE) && (count_q < CW'(QDEPTH)) && !redirect;
    imem_addr  = pc_actual;
    accept     = imem_req && imem_gnt;
    bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass     = resp && !head_valid;
`endif
    if_valid   = head_valid || bypass;
    if_instr   = 32'h0;
    if_pc      = 32'h0;
    if (head_valid) begin
      if_instr = instr_mem_q[rd_ptr_q];
      if_pc    = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      if_instr = imem_rdata;
      if_pc    = pending_pc_q;
    end
    pop  = head_valid && if_ready;
    push = resp && !(bypass && if_ready);

    if (redirect)    pc_next = redirect_pc;
    else if (accept) pc_next = pc_actual + 32'd4;
    else             pc_next = pc_actual;
  end

  always_comb begin
    state_d      = state_q;
    pending_pc_d = accept ? pc_actual : pending_pc_q;
    case (state_q)
      IDLE: if (accept) state_d = WAIT;
      // A redirect racing the response simply drops it; otherwise the response is still owed.
      WAIT: begin
        if (imem_rvalid)   state_d = IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pending_pc_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        instr_mem_q[i] <= 32'h0;
        pc_mem_q[i]    <= 32'h0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= pending_pc_q;
    end
  end

endmodule
